// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/execute single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, IF_RSP, EX_RSP} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_EX} owner_e;

  localparam int MAX_EX_STREAK_DEF = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, execute and memory-port signals; slave = arbiter side, master = stages/RAM side.
// Handshake: o_*_gnt is a same-cycle grant; a requester not granted keeps its request and inputs stable.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 32
);
  logic                  i_if_req;
  logic [ADDR_WIDTH-1:0] i_if_addr;
  logic                  i_if_flush;
  logic                  o_if_gnt;
  logic                  o_if_valid;
  logic [WORD_WIDTH-1:0] o_if_rdata;
  logic                  i_ex_req;
  logic                  i_ex_we;
  logic [ADDR_WIDTH-1:0] i_ex_addr;
  logic [WORD_WIDTH-1:0] i_ex_wdata;
  logic                  o_ex_gnt;
  logic                  o_ex_valid;
  logic [WORD_WIDTH-1:0] o_ex_rdata;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [WORD_WIDTH-1:0] o_mem_wdata;
  logic                  o_mem_write;
  logic [WORD_WIDTH-1:0] i_mem_data;
  logic [1:0]            o_dbg_state;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush, i_ex_req, i_ex_we, i_ex_addr, i_ex_wdata, i_mem_data,
    output o_if_gnt, o_if_valid, o_if_rdata, o_ex_gnt, o_ex_valid, o_ex_rdata,
           o_mem_addr, o_mem_wdata, o_mem_write, o_dbg_state
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush, i_ex_req, i_ex_we, i_ex_addr, i_ex_wdata, i_mem_data,
    input  o_if_gnt, o_if_valid, o_if_rdata, o_ex_gnt, o_ex_valid, o_ex_rdata,
           o_mem_addr, o_mem_wdata, o_mem_write, o_dbg_state
  );
endinterface

// File: rtl/mem_arbiter_streak_ctr.sv
// Saturating count of execute grants taken while fetch waits; flags when fetch must be forced through.
module arb_streak_ctr #(
  parameter int MAX_EX_STREAK = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_if_req,
  input  logic i_if_gnt,
  input  logic i_ex_gnt,
  output logic o_force_fetch
);
  localparam int CW = (MAX_EX_STREAK < 1) ? 1 : $clog2(MAX_EX_STREAK + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX_EX_STREAK);

  logic [CW-1:0] r_streak;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_streak <= '0;
    end else if (i_if_gnt || !i_if_req) begin
      r_streak <= '0;
    end else if (i_ex_gnt && (r_streak != MAX_V)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  assign o_force_fetch = (r_streak == MAX_V);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: execute normally wins, fetch is forced after MAX_EX_STREAK losses.
// Optional perf counters (conflict / fetch-starve cycles) are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int WORD_WIDTH    = 32,
  parameter int MAX_EX_STREAK = MAX_EX_STREAK_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0] o_conflict_cnt,
  output logic [31:0] o_if_starve_cnt,
`endif
  mem_arbiter_if.slave bus
);
  owner_e     w_owner;
  logic       w_force_fetch;
  logic       w_if_gnt;
  logic       w_ex_gnt;
  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_if_kill;
  logic [WORD_WIDTH-1:0] r_if_rdata;
  logic [WORD_WIDTH-1:0] r_ex_rdata;

  arb_streak_ctr #(.MAX_EX_STREAK(MAX_EX_STREAK)) u_streak (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_if_req     (bus.i_if_req),
    .i_if_gnt     (w_if_gnt),
    .i_ex_gnt     (w_ex_gnt),
    .o_force_fetch(w_force_fetch)
  );

  always_comb begin
    w_owner = OWN_NONE;
    if (bus.i_ex_req && !(bus.i_if_req && w_force_fetch)) begin
      w_owner = OWN_EX;
    end else if (bus.i_if_req) begin
      w_owner = OWN_IF;
    end
  end

  assign w_if_gnt     = (w_owner == OWN_IF);
  assign w_ex_gnt     = (w_owner == OWN_EX);
  assign bus.o_if_gnt = w_if_gnt;
  assign bus.o_ex_gnt = w_ex_gnt;

  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_write = 1'b0;
    case (w_owner)
      OWN_IF: bus.o_mem_addr = bus.i_if_addr;
      OWN_EX: begin
        bus.o_mem_addr  = bus.i_ex_addr;
        bus.o_mem_write = bus.i_ex_we;
        bus.o_mem_wdata = bus.i_ex_we ? bus.i_ex_wdata : '0;
      end
      default: ;
    endcase
  end

  // Next state only depends on this cycle's grant, so back-to-back responses stream.
  always_comb begin
    w_state_nxt = IDLE;
    if (w_if_gnt) begin
      w_state_nxt = IF_RSP;
    end else if (w_ex_gnt && !bus.i_ex_we) begin
      w_state_nxt = EX_RSP;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_if_kill  <= 1'b0;
      r_if_rdata <= '0;
      r_ex_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_if_kill <= w_if_gnt && bus.i_if_flush;
      if (w_if_gnt) r_if_rdata <= bus.i_mem_data;
      if (w_ex_gnt && !bus.i_ex_we) r_ex_rdata <= bus.i_mem_data;
    end
  end

  // A flush in the response cycle kills the fetch word combinationally.
  assign bus.o_if_valid  = (r_state == IF_RSP) && !r_if_kill && !bus.i_if_flush;
  assign bus.o_ex_valid  = (r_state == EX_RSP);
  assign bus.o_if_rdata  = r_if_rdata;
  assign bus.o_ex_rdata  = r_ex_rdata;
  assign bus.o_dbg_state = r_state;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_conflict_cnt  <= '0;
      o_if_starve_cnt <= '0;
    end else begin
      if (bus.i_if_req && bus.i_ex_req) o_conflict_cnt <= o_conflict_cnt + 32'd1;
      if (bus.i_if_req && !w_if_gnt) o_if_starve_cnt <= o_if_starve_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with a RAM model and read-data scoreboards.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int WW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt;
  logic [31:0] starve_cnt;
`endif

  mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_EX_STREAK(3)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
`ifdef MEM_ARB_PERF_EN
    .o_conflict_cnt (conflict_cnt),
    .o_if_starve_cnt(starve_cnt),
`endif
    .bus            (bus)
  );

  // RAM model: combinational read, write on the rising edge.
  logic [WW-1:0] mem     [0:1023];
  logic [WW-1:0] exp_mem [0:1023];
  assign bus.i_mem_data = mem[bus.o_mem_addr[11:2]];
  always @(posedge clk) begin
    if (bus.o_mem_write) mem[bus.o_mem_addr[11:2]] <= bus.o_mem_wdata;
  end

  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          ex_req;
    logic          ex_we;
    logic [AW-1:0] ex_addr;
    logic [WW-1:0] ex_wdata;
    logic          e_if_gnt;
    logic          e_ex_gnt;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [WW-1:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  logic [WW-1:0] exp_if_q[$];
  logic [WW-1:0] exp_ex_q[$];
  bit            if_pend, if_pend_ok, ex_pend;
  bit            if_hold_known;
  logic [WW-1:0] last_if, last_ex;
  int            n_pass = 0;
  int            n_total = 0;

  function automatic vec_t mk(input logic ir, input logic [AW-1:0] ia, input logic fl,
                              input logic er, input logic we, input logic [AW-1:0] ea,
                              input logic [WW-1:0] wd, input logic eig, input logic eeg,
                              input logic [AW-1:0] eadr, input logic ewe, input logic [WW-1:0] ewd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.if_flush = fl;
    v.ex_req = er; v.ex_we = we; v.ex_addr = ea; v.ex_wdata = wd;
    v.e_if_gnt = eig; v.e_ex_gnt = eeg; v.e_addr = eadr; v.e_we = ewe; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.i_if_req   = v.if_req;
    bus.i_if_addr  = v.if_addr;
    bus.i_if_flush = v.if_flush;
    bus.i_ex_req   = v.ex_req;
    bus.i_ex_we    = v.ex_we;
    bus.i_ex_addr  = v.ex_addr;
    bus.i_ex_wdata = v.ex_wdata;
  endtask

  task automatic clear_sb();
    exp_if_q.delete();
    exp_ex_q.delete();
    if_pend = 0; if_pend_ok = 0; ex_pend = 0;
    if_hold_known = 1; last_if = '0; last_ex = '0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [WW-1:0] d;
    bit exp_v;
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    // Responses owed from the previous cycle.
    if (if_pend) begin
      d = exp_if_q.pop_front();
      exp_v = if_pend_ok && !v.if_flush;
      chk({tag, "_if_valid"}, 32'(bus.o_if_valid), 32'(exp_v));
      if (exp_v) begin
        chk({tag, "_if_rdata"}, bus.o_if_rdata, d);
        last_if = d; if_hold_known = 1;
      end else begin
        if_hold_known = 0;
      end
    end else begin
      chk({tag, "_if_valid"}, 32'(bus.o_if_valid), 32'd0);
      if (if_hold_known) chk({tag, "_if_hold"}, bus.o_if_rdata, last_if);
    end
    if (ex_pend) begin
      d = exp_ex_q.pop_front();
      chk({tag, "_ex_valid"}, 32'(bus.o_ex_valid), 32'd1);
      chk({tag, "_ex_rdata"}, bus.o_ex_rdata, d);
      last_ex = d;
    end else begin
      chk({tag, "_ex_valid"}, 32'(bus.o_ex_valid), 32'd0);
      chk({tag, "_ex_hold"}, bus.o_ex_rdata, last_ex);
    end
    chk({tag, "_if_gnt"}, 32'(bus.o_if_gnt), 32'(v.e_if_gnt));
    chk({tag, "_ex_gnt"}, 32'(bus.o_ex_gnt), 32'(v.e_ex_gnt));
    chk({tag, "_mem_addr"}, 32'(bus.o_mem_addr), 32'(v.e_addr));
    chk({tag, "_mem_write"}, 32'(bus.o_mem_write), 32'(v.e_we));
    chk({tag, "_mem_wdata"}, bus.o_mem_wdata, v.e_wdata);
    // Book what this cycle's grant owes next cycle.
    if_pend = v.e_if_gnt;
    if_pend_ok = v.e_if_gnt && !v.if_flush;
    if (v.e_if_gnt) exp_if_q.push_back(exp_mem[v.if_addr[11:2]]);
    if (v.e_if_gnt && v.if_flush) if_hold_known = 0;
    ex_pend = v.e_ex_gnt && !v.ex_we;
    if (ex_pend) exp_ex_q.push_back(exp_mem[v.ex_addr[11:2]]);
    if (v.e_we) exp_mem[v.e_addr[11:2]] = v.e_wdata;
  endtask

  vec_t idle_v, both_v;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hF1420000 + 32'(i) * 32'h0000_0111;
      exp_mem[i] = 32'hF1420000 + 32'(i) * 32'h0000_0111;
    end
    idle_v = mk(0, 12'h000, 0, 0, 0, 12'h000, 32'h0, 0, 0, 12'h000, 0, 32'h0);
    drive(idle_v);
    clear_sb();

    // Reset values.
    #2;
    chk("rst_if_valid", 32'(bus.o_if_valid), 32'd0);
    chk("rst_ex_valid", 32'(bus.o_ex_valid), 32'd0);
    chk("rst_if_rdata", bus.o_if_rdata, 32'd0);
    chk("rst_ex_rdata", bus.o_ex_rdata, 32'd0);
    chk("rst_gnts", 32'({bus.o_if_gnt, bus.o_ex_gnt}), 32'd0);
    chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("rst_state", 32'(bus.o_dbg_state), 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("rst_conflict_cnt", conflict_cnt, 32'd0);
    chk("rst_starve_cnt", starve_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back(idle_v);
    vecs.push_back(mk(1, 12'h000, 0, 0, 0, 12'h000, 32'h0, 1, 0, 12'h000, 0, 32'h0));
    vecs.push_back(idle_v);
    vecs.push_back(mk(1, 12'h008, 0, 1, 0, 12'h010, 32'h0, 0, 1, 12'h010, 0, 32'h0));
    vecs.push_back(mk(1, 12'h008, 0, 0, 0, 12'h000, 32'h0, 1, 0, 12'h008, 0, 32'h0));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h020, 32'hDEADBEEF, 0, 1, 12'h020, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 12'h000, 0, 1, 0, 12'h020, 32'h0, 0, 1, 12'h020, 0, 32'h0));
    vecs.push_back(idle_v);
    for (int k = 0; k < 8; k++) begin
      if ((k % 4) == 3)
        vecs.push_back(mk(1, 12'h004, 0, 1, 0, 12'h00C, 32'h0, 1, 0, 12'h004, 0, 32'h0));
      else
        vecs.push_back(mk(1, 12'h004, 0, 1, 0, 12'h00C, 32'h0, 0, 1, 12'h00C, 0, 32'h0));
    end
    vecs.push_back(idle_v);
    vecs.push_back(mk(1, 12'h010, 1, 0, 0, 12'h000, 32'h0, 1, 0, 12'h010, 0, 32'h0));
    vecs.push_back(mk(1, 12'h008, 0, 0, 0, 12'h000, 32'h0, 1, 0, 12'h008, 0, 32'h0));
    vecs.push_back(idle_v);
    vecs.push_back(mk(1, 12'h004, 0, 0, 0, 12'h000, 32'h0, 1, 0, 12'h004, 0, 32'h0));
    vecs.push_back(mk(0, 12'h000, 1, 0, 0, 12'h000, 32'h0, 0, 0, 12'h000, 0, 32'h0));
    vecs.push_back(mk(1, 12'h004, 0, 1, 1, 12'h030, 32'h12345678, 0, 1, 12'h030, 1, 32'h12345678));
    vecs.push_back(mk(1, 12'h004, 0, 1, 0, 12'h030, 32'h0, 0, 1, 12'h030, 0, 32'h0));
    vecs.push_back(mk(1, 12'h004, 0, 0, 0, 12'h000, 32'h0, 1, 0, 12'h004, 0, 32'h0));
    vecs.push_back(idle_v);
    vecs.push_back(mk(0, 12'h000, 1, 1, 0, 12'h00C, 32'hA5A5A5A5, 0, 1, 12'h00C, 0, 32'h0));
    vecs.push_back(mk(0, 12'h000, 1, 0, 0, 12'h000, 32'h0, 0, 0, 12'h000, 0, 32'h0));
    vecs.push_back(idle_v);
    // Random single-requester traffic at word addresses 0x040..0x0FC.
    for (int k = 0; k < 10; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(16, 63) * 4);
      if ($urandom_range(0, 1) == 0)
        vecs.push_back(mk(1, a, 0, 0, 0, 12'h000, 32'h0, 1, 0, a, 0, 32'h0));
      else
        vecs.push_back(mk(0, 12'h000, 0, 1, 0, a, 32'h0, 0, 1, a, 0, 32'h0));
    end
    vecs.push_back(idle_v);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset in the cycle after a load grant drops the response.
    both_v = mk(1, 12'h004, 0, 1, 0, 12'h00C, 32'h0, 0, 1, 12'h00C, 0, 32'h0);
    apply(both_v, "rs_load");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rs_ex_valid_in_rst", 32'(bus.o_ex_valid), 32'd0);
    chk("rs_ex_rdata_in_rst", bus.o_ex_rdata, 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("rs_conflict_cnt", conflict_cnt, 32'd0);
    chk("rs_starve_cnt", starve_cnt, 32'd0);
`endif
    #1;
    drive(idle_v);
    rst = 1'b0;
    clear_sb();
    @(negedge clk);
    chk("rs_ex_valid_after", 32'(bus.o_ex_valid), 32'd0);
    chk("rs_if_valid_after", 32'(bus.o_if_valid), 32'd0);
    // A cleared streak gives three execute grants before fetch is forced.
    apply(both_v, "rs_s0");
    apply(both_v, "rs_s1");
    apply(both_v, "rs_s2");
    apply(mk(1, 12'h004, 0, 1, 0, 12'h00C, 32'h0, 1, 0, 12'h004, 0, 32'h0), "rs_s3");
    apply(idle_v, "rs_end");

    chk("sb_if_empty", 32'(exp_if_q.size()), 32'd0);
    chk("sb_ex_empty", 32'(exp_ex_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
